dma_multi_chan_sched: RTL and testbench

Next-generation command front end for the DMA engine. Accepts copy descriptors on N independent channels, round-robin arbitrates among them, and splits each descriptor into AXI-legal bursts (beat-aligned, no 4 KB crossing, at most MAX_BURST beats). Issues bursts on one shared command port under a global in-flight credit limit, and tracks per-burst completions to signal per-channel descriptor done. It sits between the CSR descriptor FIFOs and the read_src/write_dest FSMs.

---
 rtl/dma_multi_chan_sched.sv | 305 ++++++++++++++++++++++++++++++
 tb/tb_dma_multi_chan_sched.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_multi_chan_sched.sv
`default_nettype none
// ============================================================================
// Module   : dma_multi_chan_sched
// Purpose  : Multi-channel DMA command front end. Accepts copy descriptors on
//            N_CHANNELS channels, round-robin arbitrates among active
//            channels, splits each descriptor into AXI-legal bursts
//            (beat-aligned, never crossing a 4 KB page, at most MAX_BURST
//            beats) and issues them on one shared command port under a
//            global in-flight credit limit. Burst completions are counted
//            per channel to produce a descriptor-done pulse.
// Ports    : clk, reset              - clock, async active-high reset
//            desc_valid/ready/addr/len - per-channel descriptor intake
//            cmd_valid/ready/addr/len/chan/last - shared burst command port
//            cpl_valid/cpl_chan      - burst completion return
//            chan_busy/done/err      - per-channel status and pulses
//            outstanding             - bursts issued but not completed
// Revision : 1.0 - initial release
// ============================================================================
module dma_multi_chan_sched #(
    parameter int N_CHANNELS         = 4,
    parameter int ADDR_W             = 64,
    parameter int LEN_W              = 32,
    parameter int DATA_W             = 512,
    parameter int MAX_BURST          = 64,
    parameter int MAX_REQS_IN_FLIGHT = 16,
    localparam int CH_W              = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1,
    localparam int CNT_W             = $clog2(MAX_REQS_IN_FLIGHT + 1)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [N_CHANNELS-1:0]        desc_valid,
    output logic [N_CHANNELS-1:0]        desc_ready,
    input  logic [N_CHANNELS*ADDR_W-1:0] desc_addr,
    input  logic [N_CHANNELS*LEN_W-1:0]  desc_len,
    output logic                         cmd_valid,
    input  logic                         cmd_ready,
    output logic [ADDR_W-1:0]            cmd_addr,
    output logic [7:0]                   cmd_len,
    output logic [CH_W-1:0]              cmd_chan,
    output logic                         cmd_last,
    input  logic                         cpl_valid,
    input  logic [CH_W-1:0]              cpl_chan,
    output logic [N_CHANNELS-1:0]        chan_busy,
    output logic [N_CHANNELS-1:0]        chan_done,
    output logic [N_CHANNELS-1:0]        chan_err,
    output logic [CNT_W-1:0]             outstanding
);

    localparam int C_BEAT_BYTES = DATA_W / 8;
    localparam int C_BEAT_SHIFT = $clog2(C_BEAT_BYTES);
    localparam int C_BEATS_W    = 13;
    localparam int C_CMP_W      = (LEN_W > C_BEATS_W) ? LEN_W : C_BEATS_W;
    localparam logic [ADDR_W-1:0] C_ADDR_MASK = ADDR_W'(C_BEAT_BYTES - 1);
    localparam logic [LEN_W-1:0]  C_LEN_MASK  = LEN_W'(C_BEAT_BYTES - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DRAIN  = 2'd2
    } chan_state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    chan_state_t        r_state     [N_CHANNELS];
    chan_state_t        w_state_nxt [N_CHANNELS];
    logic [ADDR_W-1:0]  r_cur_addr  [N_CHANNELS];
    logic [LEN_W-1:0]   r_rem_beats [N_CHANNELS];
    logic [CNT_W-1:0]   r_cnt       [N_CHANNELS];
    logic [CNT_W-1:0]   w_cnt_nxt   [N_CHANNELS];

    logic [CH_W-1:0]    r_rr_ptr;
    logic [CNT_W-1:0]   r_outstanding;
    logic               r_cmd_valid;
    logic [ADDR_W-1:0]  r_cmd_addr;
    logic [7:0]         r_cmd_len;
    logic [CH_W-1:0]    r_cmd_chan;
    logic               r_cmd_last;
    logic [N_CHANNELS-1:0] r_chan_done;
    logic [N_CHANNELS-1:0] r_chan_err;

    // ------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------
    logic                  w_grant_vld;
    logic [CH_W-1:0]       w_grant;
    logic [CH_W-1:0]       w_cand;
    logic [ADDR_W-1:0]     w_g_addr;
    logic [LEN_W-1:0]      w_g_rem;
    logic [C_BEATS_W-1:0]  w_page_beats;
    logic [C_BEATS_W-1:0]  w_beats;
    logic [LEN_W-1:0]      w_rem_after;
    logic [ADDR_W-1:0]     w_burst_bytes;
    logic                  w_slot_free;
    logic                  w_credit_ok;
    logic                  w_load;

    logic [N_CHANNELS-1:0] w_accept;
    logic [N_CHANNELS-1:0] w_bad_desc;
    logic [N_CHANNELS-1:0] w_zero_len;
    logic [N_CHANNELS-1:0] w_load_c;
    logic [N_CHANNELS-1:0] w_cpl_hit;
    logic [N_CHANNELS-1:0] w_cpl_ok;
    logic [N_CHANNELS-1:0] w_done_nxt;
    logic [N_CHANNELS-1:0] w_err_nxt;
    logic [CNT_W-1:0]      w_out_nxt;

    // Modulo-N_CHANNELS add that also works for non-power-of-2 channel counts.
    function automatic logic [CH_W-1:0] wrap_add(input logic [CH_W-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= N_CHANNELS) begin
            sum = sum - N_CHANNELS;
        end
        return CH_W'(sum);
    endfunction

    // ------------------------------------------------------------------
    // Round-robin arbiter and burst sizing for the granted channel
    // ------------------------------------------------------------------
    always_comb begin
        w_grant_vld = 1'b0;
        w_grant     = '0;
        w_cand      = '0;
        for (int i = 0; i < N_CHANNELS; i++) begin
            w_cand = wrap_add(r_rr_ptr, i);
            if (!w_grant_vld && (r_state[w_cand] == ST_ACTIVE)) begin
                w_grant_vld = 1'b1;
                w_grant     = w_cand;
            end
        end

        w_g_addr = r_cur_addr[w_grant];
        w_g_rem  = r_rem_beats[w_grant];

        // Beats left before the next 4 KB boundary; always >= 1 because
        // cur_addr stays beat-aligned.
        w_page_beats = (13'd4096 - {1'b0, w_g_addr[11:0]}) >> C_BEAT_SHIFT;

        w_beats = C_BEATS_W'(MAX_BURST);
        if (w_page_beats < w_beats) begin
            w_beats = w_page_beats;
        end
        if (C_CMP_W'(w_g_rem) < C_CMP_W'(w_beats)) begin
            w_beats = C_BEATS_W'(w_g_rem);
        end

        w_rem_after   = w_g_rem - LEN_W'(w_beats);
        w_burst_bytes = ADDR_W'(w_beats) << C_BEAT_SHIFT;

        // The slot can refill in the same cycle it is being drained.
        w_slot_free = !r_cmd_valid || cmd_ready;
        w_credit_ok = r_outstanding < CNT_W'(MAX_REQS_IN_FLIGHT);
        w_load      = w_grant_vld && w_slot_free && w_credit_ok;
    end

    // ------------------------------------------------------------------
    // Per-channel next-state, counters and pulses
    // ------------------------------------------------------------------
    always_comb begin
        w_accept   = '0;
        w_bad_desc = '0;
        w_zero_len = '0;
        w_load_c   = '0;
        w_cpl_hit  = '0;
        w_cpl_ok   = '0;
        w_done_nxt = '0;
        w_err_nxt  = '0;
        for (int c = 0; c < N_CHANNELS; c++) begin
            w_state_nxt[c] = r_state[c];
            w_accept[c]    = desc_valid[c] && (r_state[c] == ST_IDLE);
            w_bad_desc[c]  = ((desc_addr[c*ADDR_W +: ADDR_W] & C_ADDR_MASK) != '0) ||
                             ((desc_len[c*LEN_W +: LEN_W] & C_LEN_MASK) != '0);
            w_zero_len[c]  = (desc_len[c*LEN_W +: LEN_W] == '0);
            w_load_c[c]    = w_load && (w_grant == CH_W'(c));
            w_cpl_hit[c]   = cpl_valid && (cpl_chan == CH_W'(c));
            // A completion with nothing outstanding on that channel is spurious
            // and leaves the counters untouched.
            w_cpl_ok[c]    = w_cpl_hit[c] && (r_cnt[c] != '0);
            w_cnt_nxt[c]   = r_cnt[c] + CNT_W'(w_load_c[c]) - CNT_W'(w_cpl_ok[c]);

            w_err_nxt[c]   = (w_accept[c] && w_bad_desc[c]) ||
                             (w_cpl_hit[c] && (r_cnt[c] == '0));

            case (r_state[c])
                ST_IDLE: begin
                    if (w_accept[c] && !w_bad_desc[c]) begin
                        if (w_zero_len[c]) begin
                            w_done_nxt[c] = 1'b1;
                        end else begin
                            w_state_nxt[c] = ST_ACTIVE;
                        end
                    end
                end
                ST_ACTIVE: begin
                    if (w_load_c[c] && (w_rem_after == '0)) begin
                        w_state_nxt[c] = ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (w_cnt_nxt[c] == '0) begin
                        w_done_nxt[c]  = 1'b1;
                        w_state_nxt[c] = ST_IDLE;
                    end
                end
                default: begin
                    w_state_nxt[c] = ST_IDLE;
                end
            endcase
        end
        w_out_nxt = r_outstanding + CNT_W'(w_load) - CNT_W'(|w_cpl_ok);
    end

    // ------------------------------------------------------------------
    // Channel state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < N_CHANNELS; c++) begin
                r_state[c] <= ST_IDLE;
            end
        end else begin
            for (int c = 0; c < N_CHANNELS; c++) begin
                r_state[c] <= w_state_nxt[c];
            end
        end
    end

    // ------------------------------------------------------------------
    // Channel datapath: cursor, remaining beats, in-flight count
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < N_CHANNELS; c++) begin
                r_cur_addr[c]  <= '0;
                r_rem_beats[c] <= '0;
                r_cnt[c]       <= '0;
            end
        end else begin
            for (int c = 0; c < N_CHANNELS; c++) begin
                r_cnt[c] <= w_cnt_nxt[c];
                if (w_accept[c] && !w_bad_desc[c] && !w_zero_len[c]) begin
                    r_cur_addr[c]  <= desc_addr[c*ADDR_W +: ADDR_W];
                    r_rem_beats[c] <= desc_len[c*LEN_W +: LEN_W] >> C_BEAT_SHIFT;
                end else if (w_load_c[c]) begin
                    r_cur_addr[c]  <= r_cur_addr[c] + w_burst_bytes;
                    r_rem_beats[c] <= w_rem_after;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Issue slot, RR pointer, global credit and status pulses
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rr_ptr      <= '0;
            r_outstanding <= '0;
            r_cmd_valid   <= 1'b0;
            r_cmd_addr    <= '0;
            r_cmd_len     <= '0;
            r_cmd_chan    <= '0;
            r_cmd_last    <= 1'b0;
            r_chan_done   <= '0;
            r_chan_err    <= '0;
        end else begin
            r_outstanding <= w_out_nxt;
            r_chan_done   <= w_done_nxt;
            r_chan_err    <= w_err_nxt;
            if (w_load) begin
                r_cmd_valid <= 1'b1;
                r_cmd_addr  <= w_g_addr;
                r_cmd_len   <= 8'(w_beats - 13'd1);
                r_cmd_chan  <= w_grant;
                r_cmd_last  <= (w_rem_after == '0);
                r_rr_ptr    <= wrap_add(w_grant, 1);
            end else if (cmd_ready) begin
                r_cmd_valid <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    generate
        for (genvar g = 0; g < N_CHANNELS; g++) begin : g_status
            // Held low while reset is asserted so every output reads 0.
            assign desc_ready[g] = (r_state[g] == ST_IDLE) && !reset;
            assign chan_busy[g]  = (r_state[g] != ST_IDLE);
        end
    endgenerate

    assign cmd_valid   = r_cmd_valid;
    assign cmd_addr    = r_cmd_addr;
    assign cmd_len     = r_cmd_len;
    assign cmd_chan    = r_cmd_chan;
    assign cmd_last    = r_cmd_last;
    assign chan_done   = r_chan_done;
    assign chan_err    = r_chan_err;
    assign outstanding = r_outstanding;

endmodule
`default_nettype wire

// File: tb/tb_dma_multi_chan_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_dma_multi_chan_sched
// Purpose  : Directed self-checking bench for dma_multi_chan_sched with the
//            default parameter set (4 channels, 64-byte beats, 64-beat bursts,
//            16 bursts in flight).
// Revision : 1.0 - initial release
// ============================================================================
module tb_dma_multi_chan_sched;

    localparam int N  = 4;
    localparam int AW = 64;
    localparam int LW = 32;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [N-1:0]    desc_valid = '0;
    logic [N-1:0]    desc_ready;
    logic [N*AW-1:0] desc_addr = '0;
    logic [N*LW-1:0] desc_len = '0;
    logic            cmd_valid;
    logic            cmd_ready = 1'b0;
    logic [AW-1:0]   cmd_addr;
    logic [7:0]      cmd_len;
    logic [1:0]      cmd_chan;
    logic            cmd_last;
    logic            cpl_valid = 1'b0;
    logic [1:0]      cpl_chan = '0;
    logic [N-1:0]    chan_busy;
    logic [N-1:0]    chan_done;
    logic [N-1:0]    chan_err;
    logic [4:0]      outstanding;

    dma_multi_chan_sched dut (
        .clk         (clk),
        .reset       (reset),
        .desc_valid  (desc_valid),
        .desc_ready  (desc_ready),
        .desc_addr   (desc_addr),
        .desc_len    (desc_len),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_addr    (cmd_addr),
        .cmd_len     (cmd_len),
        .cmd_chan    (cmd_chan),
        .cmd_last    (cmd_last),
        .cpl_valid   (cpl_valid),
        .cpl_chan    (cpl_chan),
        .chan_busy   (chan_busy),
        .chan_done   (chan_done),
        .chan_err    (chan_err),
        .outstanding (outstanding)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Command-port and pulse monitor, cleared whenever reset is high.
    logic [63:0] m_addr[$];
    logic [7:0]  m_len[$];
    logic [1:0]  m_chan[$];
    logic        m_last[$];
    int          m_cyc[$];
    int          done_cnt[N];

    always @(negedge clk) begin
        if (reset) begin
            m_addr.delete(); m_len.delete(); m_chan.delete();
            m_last.delete(); m_cyc.delete();
            for (int c = 0; c < N; c++) done_cnt[c] = 0;
        end else begin
            if (cmd_valid && cmd_ready) begin
                m_addr.push_back(cmd_addr);
                m_len.push_back(cmd_len);
                m_chan.push_back(cmd_chan);
                m_last.push_back(cmd_last);
                m_cyc.push_back(cyc);
            end
            for (int c = 0; c < N; c++) if (chan_done[c]) done_cnt[c] = done_cnt[c] + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        desc_valid = '0; cpl_valid = 1'b0; cmd_ready = 1'b0;
        desc_addr = '0; desc_len = '0; cpl_chan = '0;
        repeat (2) tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic set_desc(input int ch, input logic [63:0] a, input logic [31:0] l);
        desc_addr[ch*AW +: AW] = a;
        desc_len[ch*LW +: LW]  = l;
        desc_valid[ch]         = 1'b1;
    endtask

    task automatic wait_cmds(input int n, input int budget);
        for (int i = 0; i < budget && m_addr.size() < n; i++) tick();
    endtask

    task automatic send_cpl(input logic [1:0] ch);
        cpl_chan = ch; cpl_valid = 1'b1;
        tick();
        cpl_valid = 1'b0;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        do_reset();
        n_tests++; if (desc_ready !== 4'hF) begin n_fail++; $display("FAIL rst_desc_ready: got %h want f", desc_ready); end
        n_tests++; if (cmd_valid !== 1'b0) begin n_fail++; $display("FAIL rst_cmd_valid: got %b want 0", cmd_valid); end
        n_tests++; if (outstanding !== 5'd0) begin n_fail++; $display("FAIL rst_outstanding: got %0d want 0", outstanding); end
        n_tests++; if ({chan_busy, chan_done, chan_err} !== 12'h0) begin n_fail++; $display("FAIL rst_status: got %h want 0", {chan_busy, chan_done, chan_err}); end
    endtask

    task automatic test_single();
        logic [63:0] ea;
        do_reset();
        cmd_ready = 1'b1;
        set_desc(0, 64'h1000, 32'h4000);
        tick();
        desc_valid = '0;
        n_tests++; if (cmd_valid !== 1'b0) begin n_fail++; $display("FAIL single_lat_t1: got %b want 0", cmd_valid); end
        tick();
        n_tests++; if (cmd_valid !== 1'b1) begin n_fail++; $display("FAIL single_lat_t2: got %b want 1", cmd_valid); end
        wait_cmds(4, 20);
        n_tests++; if (m_addr.size() !== 4) begin n_fail++; $display("FAIL single_count: got %0d want 4", m_addr.size()); end
        for (int i = 0; i < 4 && i < m_addr.size(); i++) begin
            ea = 64'h1000 * (i + 1);
            n_tests++; if (m_addr[i] !== ea || m_len[i] !== 8'd63 || m_last[i] !== (i == 3) || m_chan[i] !== 2'd0) begin
                n_fail++; $display("FAIL single_burst%0d: got a=%h l=%0d last=%b ch=%0d want a=%h l=63 last=%b ch=0", i, m_addr[i], m_len[i], m_last[i], m_chan[i], ea, (i == 3));
            end
        end
        n_tests++; if (outstanding !== 5'd4) begin n_fail++; $display("FAIL single_outstanding: got %0d want 4", outstanding); end
        n_tests++; if (chan_busy !== 4'b0001) begin n_fail++; $display("FAIL single_busy: got %b want 0001", chan_busy); end
        cpl_chan = 2'd0; cpl_valid = 1'b1;
        repeat (3) tick();
        n_tests++; if (chan_done !== 4'b0000) begin n_fail++; $display("FAIL single_early_done: got %b want 0000", chan_done); end
        tick();
        cpl_valid = 1'b0;
        n_tests++; if (chan_done !== 4'b0001) begin n_fail++; $display("FAIL single_done_pulse: got %b want 0001", chan_done); end
        n_tests++; if (outstanding !== 5'd0 || desc_ready !== 4'hF) begin n_fail++; $display("FAIL single_after_done: got out=%0d rdy=%h want out=0 rdy=f", outstanding, desc_ready); end
        tick();
        n_tests++; if (chan_done !== 4'b0000 || done_cnt[0] !== 1) begin n_fail++; $display("FAIL single_done_once: got pulse=%b count=%0d want 0000/1", chan_done, done_cnt[0]); end
    endtask

    task automatic test_4k_split();
        do_reset();
        cmd_ready = 1'b1;
        set_desc(1, 64'h0FC0, 32'h100);
        tick();
        desc_valid = '0;
        wait_cmds(2, 20);
        repeat (3) tick();
        n_tests++; if (m_addr.size() !== 2) begin n_fail++; $display("FAIL split_count: got %0d want 2", m_addr.size()); end
        if (m_addr.size() >= 2) begin
            n_tests++; if (m_addr[0] !== 64'h0FC0 || m_len[0] !== 8'd0 || m_last[0] !== 1'b0 || m_chan[0] !== 2'd1) begin
                n_fail++; $display("FAIL split_b0: got a=%h l=%0d last=%b ch=%0d want a=fc0 l=0 last=0 ch=1", m_addr[0], m_len[0], m_last[0], m_chan[0]);
            end
            n_tests++; if (m_addr[1] !== 64'h1000 || m_len[1] !== 8'd2 || m_last[1] !== 1'b1 || m_chan[1] !== 2'd1) begin
                n_fail++; $display("FAIL split_b1: got a=%h l=%0d last=%b ch=%0d want a=1000 l=2 last=1 ch=1", m_addr[1], m_len[1], m_last[1], m_chan[1]);
            end
        end
        send_cpl(2'd1);
        send_cpl(2'd1);
        tick();
        n_tests++; if (done_cnt[1] !== 1 || outstanding !== 5'd0) begin n_fail++; $display("FAIL split_done: got count=%0d out=%0d want 1/0", done_cnt[1], outstanding); end
    endtask

    task automatic test_round_robin();
        logic [1:0]  ech [6];
        logic [63:0] ead [6];
        ech = '{2'd0, 2'd2, 2'd3, 2'd0, 2'd2, 2'd3};
        ead = '{64'h0, 64'h10000, 64'h20000, 64'h1000, 64'h11000, 64'h21000};
        do_reset();
        cmd_ready = 1'b1;
        set_desc(0, 64'h0, 32'h2000);
        set_desc(2, 64'h10000, 32'h2000);
        set_desc(3, 64'h20000, 32'h2000);
        tick();
        desc_valid = '0;
        wait_cmds(6, 30);
        repeat (2) tick();
        n_tests++; if (m_addr.size() !== 6) begin n_fail++; $display("FAIL rr_count: got %0d want 6", m_addr.size()); end
        for (int i = 0; i < 6 && i < m_addr.size(); i++) begin
            n_tests++; if (m_chan[i] !== ech[i] || m_addr[i] !== ead[i] || m_last[i] !== (i >= 3) || m_cyc[i] !== m_cyc[0] + i) begin
                n_fail++; $display("FAIL rr_burst%0d: got ch=%0d a=%h last=%b dcyc=%0d want ch=%0d a=%h last=%b dcyc=%0d",
                                   i, m_chan[i], m_addr[i], m_last[i], m_cyc[i] - m_cyc[0], ech[i], ead[i], (i >= 3), i);
            end
        end
        n_tests++; if (outstanding !== 5'd6) begin n_fail++; $display("FAIL rr_outstanding: got %0d want 6", outstanding); end
        send_cpl(2'd0); send_cpl(2'd2); send_cpl(2'd3);
        send_cpl(2'd0); send_cpl(2'd2); send_cpl(2'd3);
        tick();
        n_tests++; if (done_cnt[0] !== 1 || done_cnt[2] !== 1 || done_cnt[3] !== 1 || done_cnt[1] !== 0) begin
            n_fail++; $display("FAIL rr_done: got %0d%0d%0d%0d want 1011 (ch0..3)", done_cnt[0], done_cnt[1], done_cnt[2], done_cnt[3]);
        end
    endtask

    task automatic test_credit_limit();
        do_reset();
        cmd_ready = 1'b1;
        set_desc(1, 64'h0, 32'h11000);
        tick();
        desc_valid = '0;
        repeat (40) tick();
        n_tests++; if (m_addr.size() !== 16) begin n_fail++; $display("FAIL credit_issued: got %0d want 16", m_addr.size()); end
        n_tests++; if (cmd_valid !== 1'b0 || outstanding !== 5'd16) begin n_fail++; $display("FAIL credit_stall: got valid=%b out=%0d want 0/16", cmd_valid, outstanding); end
        send_cpl(2'd1);
        repeat (10) tick();
        n_tests++; if (m_addr.size() !== 17) begin n_fail++; $display("FAIL credit_one_more: got %0d want 17", m_addr.size()); end
        n_tests++; if (outstanding !== 5'd16) begin n_fail++; $display("FAIL credit_outstanding: got %0d want 16", outstanding); end
        if (m_addr.size() >= 17) begin
            n_tests++; if (m_addr[16] !== 64'h10000 || m_last[16] !== 1'b1) begin n_fail++; $display("FAIL credit_last_burst: got a=%h last=%b want a=10000 last=1", m_addr[16], m_last[16]); end
        end
    endtask

    task automatic test_errors();
        do_reset();
        cmd_ready = 1'b1;
        set_desc(2, 64'h1004, 32'h40);
        tick();
        desc_valid = '0;
        n_tests++; if (chan_err !== 4'b0100) begin n_fail++; $display("FAIL err_misalign: got %b want 0100", chan_err); end
        n_tests++; if (desc_ready !== 4'hF || chan_busy !== 4'h0) begin n_fail++; $display("FAIL err_idle: got rdy=%h busy=%h want f/0", desc_ready, chan_busy); end
        tick();
        n_tests++; if (chan_err !== 4'b0000) begin n_fail++; $display("FAIL err_one_cycle: got %b want 0000", chan_err); end
        set_desc(0, 64'h0, 32'h41);
        tick();
        desc_valid = '0;
        n_tests++; if (chan_err !== 4'b0001) begin n_fail++; $display("FAIL err_len: got %b want 0001", chan_err); end
        send_cpl(2'd1);
        n_tests++; if (chan_err !== 4'b0010 || outstanding !== 5'd0) begin n_fail++; $display("FAIL err_spurious: got err=%b out=%0d want 0010/0", chan_err, outstanding); end
        set_desc(3, 64'h2000, 32'h0);
        tick();
        desc_valid = '0;
        n_tests++; if (chan_done !== 4'b1000 || chan_err !== 4'b0000) begin n_fail++; $display("FAIL err_zero_len: got done=%b err=%b want 1000/0000", chan_done, chan_err); end
        repeat (5) tick();
        n_tests++; if (m_addr.size() !== 0) begin n_fail++; $display("FAIL err_no_cmd: got %0d cmds want 0", m_addr.size()); end
    endtask

    task automatic test_backpressure_reset();
        logic [75:0] held;
        do_reset();
        cmd_ready = 1'b0;
        set_desc(0, 64'h1000, 32'h4000);
        tick();
        desc_valid = '0;
        tick();
        n_tests++; if (cmd_valid !== 1'b1 || cmd_addr !== 64'h1000) begin n_fail++; $display("FAIL bp_first: got valid=%b a=%h want 1/1000", cmd_valid, cmd_addr); end
        held = {cmd_valid, cmd_addr, cmd_len, cmd_chan, cmd_last};
        for (int i = 0; i < 10; i++) begin
            tick();
            n_tests++; if ({cmd_valid, cmd_addr, cmd_len, cmd_chan, cmd_last} !== held) begin
                n_fail++; $display("FAIL bp_hold%0d: got %h want %h", i, {cmd_valid, cmd_addr, cmd_len, cmd_chan, cmd_last}, held);
            end
        end
        n_tests++; if (outstanding !== 5'd1) begin n_fail++; $display("FAIL bp_outstanding: got %0d want 1", outstanding); end
        reset = 1'b1;
        #1;
        n_tests++; if ({cmd_valid, cmd_addr, cmd_len, cmd_chan, cmd_last} !== 76'h0 || outstanding !== 5'd0) begin
            n_fail++; $display("FAIL rst_async_cmd: got %h out=%0d want 0/0", {cmd_valid, cmd_addr, cmd_len, cmd_chan, cmd_last}, outstanding);
        end
        n_tests++; if ({desc_ready, chan_busy, chan_done, chan_err} !== 16'h0) begin
            n_fail++; $display("FAIL rst_async_status: got %h want 0", {desc_ready, chan_busy, chan_done, chan_err});
        end
        tick();
        reset = 1'b0;
        #1;
        n_tests++; if (desc_ready !== 4'hF || outstanding !== 5'd0) begin n_fail++; $display("FAIL rst_release: got rdy=%h out=%0d want f/0", desc_ready, outstanding); end
        send_cpl(2'd0);
        n_tests++; if (chan_err !== 4'b0001 || outstanding !== 5'd0) begin n_fail++; $display("FAIL rst_late_cpl: got err=%b out=%0d want 0001/0", chan_err, outstanding); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_4k_split();
        test_round_robin();
        test_credit_limit();
        test_errors();
        test_backpressure_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
